seq_bin2bcd_display: RTL and testbench

- Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Drives one 7-segment display per decimal digit, with optional leading-zero blanking and an overflow flag.
- Generalises the 4-bit, two-digit combinational converter to WIDTH-bit inputs and DIGITS decimal digits, with a start/busy/done handshake.
- Sits between switch or datapath values and the HEX display bank.

---
 rtl/seq_bin2bcd_display.sv | 119 +++++++++++
 tb/tb_seq_bin2bcd_display.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_bin2bcd_display.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock,
// feeding a bank of 7-segment displays with optional leading-zero blanking.
module seq_bin2bcd_display #(
  parameter int WIDTH          = 8,
  parameter int DIGITS         = 3,
  parameter int BLANK_LEADING  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]          state;
  logic [WIDTH-1:0]    bin_sr;
  logic [4*DIGITS-1:0] scratch;
  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] scratch_nxt;
  logic [CW-1:0]       cnt;
  logic                ovf_acc;
  logic                ovf_out;

  always_comb begin
    adj = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5)
        adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
  end

  // The bit leaving the top digit is a carry of 10^DIGITS; dropping it keeps bin mod 10^DIGITS.
  assign scratch_nxt = {adj[4*DIGITS-2:0], bin_sr[WIDTH-1]};
  assign ovf_out     = adj[4*DIGITS-1];
  assign busy        = (state == S_SHIFT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      bin_sr   <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_acc  <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            bin_sr  <= bin;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
            ovf_acc <= 1'b0;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scratch <= scratch_nxt;
          bin_sr  <= bin_sr << 1;
          cnt     <= cnt - CW'(1);
          ovf_acc <= ovf_acc | ovf_out;
          if (cnt == CW'(1)) begin
            bcd      <= scratch_nxt;
            overflow <= ovf_acc | ovf_out;
            done     <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  logic       higher_nz;
  logic [6:0] seg;

  // Decoded only from the result register, so the displays never show scratch values.
  always_comb begin
    hex       = '0;
    higher_nz = 1'b0;
    seg       = 7'b1111111;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      higher_nz = higher_nz | (bcd[4*i +: 4] != 4'd0);
      if (BLANK_LEADING != 0 && i != 0 && !higher_nz)
        seg = 7'b1111111;
      else
        seg = seg_of(bcd[4*i +: 4]);
      hex[7*i +: 7] = (SEG_ACTIVE_LOW != 0) ? seg : ~seg;
    end
  end

endmodule

// File: tb/tb_seq_bin2bcd_display.sv
// Bench for seq_bin2bcd_display: three instances share one stimulus stream
// (default, no blanking, two digits with active-high segments).
module tb_seq_bin2bcd_display;

  logic clk = 1'b0;
  logic reset, start;
  logic [7:0] bin;

  logic busy_a, done_a, ovf_a;  logic [11:0] bcd_a; logic [20:0] hex_a;
  logic busy_b, done_b, ovf_b;  logic [11:0] bcd_b; logic [20:0] hex_b;
  logic busy_c, done_c, ovf_c;  logic [7:0]  bcd_c; logic [13:0] hex_c;

  int cmp_count = 0;
  int err_count = 0;
  int last_a    = 0;

  always #5 clk = ~clk;

  seq_bin2bcd_display #(.WIDTH(8), .DIGITS(3), .BLANK_LEADING(1), .SEG_ACTIVE_LOW(1)) u_a (
    .clock(clk), .reset(reset), .start(start), .bin(bin), .busy(busy_a), .done(done_a),
    .overflow(ovf_a), .bcd(bcd_a), .hex(hex_a));
  seq_bin2bcd_display #(.WIDTH(8), .DIGITS(3), .BLANK_LEADING(0), .SEG_ACTIVE_LOW(1)) u_b (
    .clock(clk), .reset(reset), .start(start), .bin(bin), .busy(busy_b), .done(done_b),
    .overflow(ovf_b), .bcd(bcd_b), .hex(hex_b));
  seq_bin2bcd_display #(.WIDTH(8), .DIGITS(2), .BLANK_LEADING(1), .SEG_ACTIVE_LOW(0)) u_c (
    .clock(clk), .reset(reset), .start(start), .bin(bin), .busy(busy_c), .done(done_c),
    .overflow(ovf_c), .bcd(bcd_c), .hex(hex_c));

  // Reference model: decimal digits by division, segment table from the digit glyphs.
  function automatic logic [11:0] exp_bcd(input int v, input int d);
    logic [11:0] r = '0;
    for (int i = 0; i < d; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    return r;
  endfunction

  function automatic logic [6:0] glyph(input int dig);
    case (dig)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [20:0] exp_hex(input int v, input int d, input bit blank, input bit act_low);
    logic [20:0] r = '0;
    logic [6:0]  s;
    int m = v % (10 ** d);
    for (int i = 0; i < d; i++) begin
      if (blank && i > 0 && (m / (10 ** i)) == 0) s = 7'b1111111;
      else s = glyph((m / (10 ** i)) % 10);
      if (!act_low) s = ~s;
      r[7*i +: 7] = s;
    end
    return r;
  endfunction

  task automatic test_reset();
    logic [20:0] hc;
    @(negedge clk); reset = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    cmp_count++;
    if ({busy_a, done_a, ovf_a, bcd_a, hex_a} !== {3'b000, 12'h000, 14'h3fff, 7'b1000000}) begin
      err_count++;
      $display("FAIL reset_a: got busy=%b done=%b ovf=%b bcd=%h hex=%b want 0 0 0 000 %b",
               busy_a, done_a, ovf_a, bcd_a, hex_a, {14'h3fff, 7'b1000000});
    end
    cmp_count++;
    if ({busy_b, done_b, ovf_b, bcd_b, hex_b} !== {3'b000, 12'h000, {3{7'b1000000}}}) begin
      err_count++;
      $display("FAIL reset_b: got ovf=%b bcd=%h hex=%b", ovf_b, bcd_b, hex_b);
    end
    hc = exp_hex(0, 2, 1'b1, 1'b0);
    cmp_count++;
    if ({busy_c, done_c, ovf_c, bcd_c, hex_c} !== {3'b000, 8'h00, hc[13:0]}) begin
      err_count++;
      $display("FAIL reset_c: got ovf=%b bcd=%h hex=%b want hex=%b", ovf_c, bcd_c, hex_c, hc[13:0]);
    end
    reset = 1'b0;
    last_a = 0;
  endtask

  // One full conversion: latency, busy length, result hold during conversion, final values.
  task automatic test_conversion(input int v);
    logic [20:0] ha, hb, hc, hl;
    logic [11:0] bc;
    @(negedge clk); start = 1'b1; bin = 8'(v);
    @(negedge clk); start = 1'b0; bin = 8'($urandom_range(0, 255));
    hl = exp_hex(last_a, 3, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cmp_count++;
      if ({busy_a, done_a, bcd_a, hex_a} !== {2'b10, exp_bcd(last_a, 3), hl}) begin
        err_count++;
        $display("FAIL busy_hold k=%0d: got busy=%b done=%b bcd=%h want 1 0 %h",
                 k, busy_a, done_a, bcd_a, exp_bcd(last_a, 3));
      end
      @(negedge clk);
    end
    ha = exp_hex(v, 3, 1'b1, 1'b1);
    hb = exp_hex(v, 3, 1'b0, 1'b1);
    hc = exp_hex(v, 2, 1'b1, 1'b0);
    bc = exp_bcd(v, 2);
    cmp_count++;
    if ({busy_a, done_a, ovf_a, bcd_a, hex_a} !== {2'b01, 1'b0, exp_bcd(v, 3), ha}) begin
      err_count++;
      $display("FAIL conv_a v=%0d: got busy=%b done=%b ovf=%b bcd=%h hex=%b want 0 1 0 %h %b",
               v, busy_a, done_a, ovf_a, bcd_a, hex_a, exp_bcd(v, 3), ha);
    end
    cmp_count++;
    if ({done_b, bcd_b, hex_b} !== {1'b1, exp_bcd(v, 3), hb}) begin
      err_count++;
      $display("FAIL conv_b v=%0d: got bcd=%h hex=%b want %h %b", v, bcd_b, hex_b, exp_bcd(v, 3), hb);
    end
    cmp_count++;
    if ({done_c, ovf_c, bcd_c, hex_c} !== {1'b1, (v >= 100), bc[7:0], hc[13:0]}) begin
      err_count++;
      $display("FAIL conv_c v=%0d: got ovf=%b bcd=%h hex=%b want %b %h %b",
               v, ovf_c, bcd_c, hex_c, (v >= 100), bc[7:0], hc[13:0]);
    end
    @(negedge clk);
    cmp_count++;
    if ({busy_a, done_a} !== 2'b00) begin
      err_count++;
      $display("FAIL done_pulse v=%0d: got busy=%b done=%b want 0 0", v, busy_a, done_a);
    end
    last_a = v;
  endtask

  task automatic test_directed();
    test_conversion(245);
    test_conversion(9);
    test_conversion(255);
    test_conversion(99);
    test_conversion(0);
    test_conversion(100);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) test_conversion(int'($urandom_range(0, 255)));
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    int t_first = -1, t_second = -1;
    logic [11:0] got_first = '0, got_second = '0;
    @(negedge clk); start = 1'b1; bin = 8'd100;
    for (int c = 0; c < 40 && ndone < 2; c++) begin
      @(negedge clk);
      if (c == 3) bin = 8'd37;
      if (done_a) begin
        if (ndone == 0) begin t_first = c; got_first = bcd_a; end
        else begin t_second = c; got_second = bcd_a; start = 1'b0; end
        ndone++;
      end
    end
    start = 1'b0;
    cmp_count++;
    if (ndone != 2) begin
      err_count++;
      $display("FAIL b2b_timeout: got %0d done pulses want 2", ndone);
    end
    cmp_count++;
    if (got_first !== 12'h100 || got_second !== 12'h037) begin
      err_count++;
      $display("FAIL b2b_values: got %h %h want 100 037", got_first, got_second);
    end
    cmp_count++;
    if (t_first != 8 || t_second - t_first != 9) begin
      err_count++;
      $display("FAIL b2b_timing: got first=%0d gap=%0d want 8 9", t_first, t_second - t_first);
    end
    @(negedge clk);
    last_a = 37;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    test_conversion(245);
    @(negedge clk); start = 1'b1; bin = 8'd17;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    cmp_count++;
    if ({busy_a, done_a, ovf_a, bcd_a} !== {3'b000, 12'h000}) begin
      err_count++;
      $display("FAIL reset_mid: got busy=%b done=%b ovf=%b bcd=%h want 0 0 0 000", busy_a, done_a, ovf_a, bcd_a);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done_a || busy_a) seen++;
    end
    cmp_count++;
    if (seen != 0) begin
      err_count++;
      $display("FAIL reset_discard: got %0d busy/done cycles want 0", seen);
    end
    last_a = 0;
    test_conversion(17);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; bin = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
